// File: rtl/rot_rs.sv
// Reservation station for the rotate/shift unit: operand wake-up via CDB snoop,
// lowest-index allocate/issue. Define ROT_RS_BYPASS_EN for same-cycle dispatch-to-issue bypass.
package rot_rs_pkg;
  typedef struct packed {
    logic [1:0] kind;
    logic       dir_left;
    logic       arith;
    logic [4:0] amount;
    logic       use_imm;
  } rotate_decode_t;
endpackage

module rot_rs
  import rot_rs_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned RS_ID_WIDTH = 5,
  parameter int unsigned RS_ID_BASE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  logic [31:0]            op1,
  input  logic [31:0]            op2,
  input  logic [31:0]            target,
  input  logic                   op1_valid,
  input  logic                   op2_valid,
  input  logic                   target_valid,
  input  logic [RS_ID_WIDTH-1:0] op1_tag,
  input  logic [RS_ID_WIDTH-1:0] op2_tag,
  input  logic [RS_ID_WIDTH-1:0] target_tag,
  input  rotate_decode_t         control_in,
  input  logic [4:0]             result_reg_addr_in,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] issue_rs_id,
  output logic [4:0]             issue_result_reg_addr,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2,
  output logic [31:0]            issue_target,
  output rotate_decode_t         issue_control
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NOPS  = 3;

  logic [DEPTH-1:0]       r_busy;
  logic [NOPS-1:0]        r_vld  [DEPTH];
  logic [31:0]            r_val  [DEPTH][NOPS];
  logic [RS_ID_WIDTH-1:0] r_tag  [DEPTH][NOPS];
  rotate_decode_t         r_ctrl [DEPTH];
  logic [4:0]             r_rd   [DEPTH];

  logic [31:0]            w_in_val [NOPS];
  logic [RS_ID_WIDTH-1:0] w_in_tag [NOPS];
  logic [NOPS-1:0]        w_in_vld;
  logic [31:0]            w_d_val  [NOPS];
  logic [NOPS-1:0]        w_d_vld;

  logic                   w_free_found;
  logic [IDX_W-1:0]       w_free_idx;
  logic                   w_iss_found;
  logic [IDX_W-1:0]       w_iss_idx;
  logic                   w_dispatch_fire;
  logic                   w_bypass;
  logic                   w_alloc;
  logic                   w_issue_fire;

  function automatic logic [RS_ID_WIDTH-1:0] f_id(input logic [IDX_W-1:0] idx);
    return RS_ID_WIDTH'(RS_ID_BASE + 32'(idx));
  endfunction

  // Incoming operands snoop the concurrent broadcast so they never miss a wake-up
  always_comb begin
    w_in_val[0] = op1;
    w_in_val[1] = op2;
    w_in_val[2] = target;
    w_in_tag[0] = op1_tag;
    w_in_tag[1] = op2_tag;
    w_in_tag[2] = target_tag;
    w_in_vld    = {target_valid, op2_valid, op1_valid};
    for (int unsigned k = 0; k < NOPS; k++) begin
      w_d_val[k] = w_in_val[k];
      w_d_vld[k] = w_in_vld[k];
      if (!w_in_vld[k] && cdb_valid && (cdb_rs_id == w_in_tag[k])) begin
        w_d_val[k] = cdb_result;
        w_d_vld[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_iss_found  = 1'b0;
    w_iss_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!w_free_found && !r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (!w_iss_found && r_busy[i] && (&r_vld[i])) begin
        w_iss_found = 1'b1;
        w_iss_idx   = IDX_W'(i);
      end
    end
  end

  assign dispatch_ready  = rst & w_free_found;
  assign w_dispatch_fire = dispatch_valid & dispatch_ready;

  always_comb begin
    issue_valid           = 1'b0;
    issue_rs_id           = '0;
    issue_result_reg_addr = '0;
    issue_op1             = '0;
    issue_op2             = '0;
    issue_target          = '0;
    issue_control         = '0;
    w_bypass              = 1'b0;
    if (rst) begin
      if (w_iss_found) begin
        issue_valid           = 1'b1;
        issue_rs_id           = f_id(w_iss_idx);
        issue_result_reg_addr = r_rd[w_iss_idx];
        issue_op1             = r_val[w_iss_idx][0];
        issue_op2             = r_val[w_iss_idx][1];
        issue_target          = r_val[w_iss_idx][2];
        issue_control         = r_ctrl[w_iss_idx];
      end
`ifdef ROT_RS_BYPASS_EN
      else if (w_dispatch_fire && (&w_d_vld) && issue_ready) begin
        w_bypass              = 1'b1;
        issue_valid           = 1'b1;
        issue_rs_id           = f_id(w_free_idx);
        issue_result_reg_addr = result_reg_addr_in;
        issue_op1             = w_d_val[0];
        issue_op2             = w_d_val[1];
        issue_target          = w_d_val[2];
        issue_control         = control_in;
      end
`endif
    end
  end

  assign w_alloc      = w_dispatch_fire & ~w_bypass;
  assign w_issue_fire = rst & w_iss_found & issue_ready;

  // Allocation targets a free entry and issue a busy one, so the two never collide
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_vld[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_alloc && (w_free_idx == IDX_W'(i))) begin
          r_busy[i] <= 1'b1;
          r_vld[i]  <= w_d_vld;
          r_ctrl[i] <= control_in;
          r_rd[i]   <= result_reg_addr_in;
          for (int unsigned k = 0; k < NOPS; k++) begin
            r_val[i][k] <= w_d_val[k];
            r_tag[i][k] <= w_in_tag[k];
          end
        end else if (w_issue_fire && (w_iss_idx == IDX_W'(i))) begin
          r_busy[i] <= 1'b0;
          r_vld[i]  <= '0;
        end else if (r_busy[i]) begin
          for (int unsigned k = 0; k < NOPS; k++) begin
            if (!r_vld[i][k] && cdb_valid && (cdb_rs_id == r_tag[i][k])) begin
              r_val[i][k] <= cdb_result;
              r_vld[i][k] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rot_rs.sv
// Directed self-checking bench for rot_rs (RS IDs based at 16, depth 4).
module tb_rot_rs;
  import rot_rs_pkg::*;

  localparam int unsigned BASE = 16;

  logic           clk;
  logic           rst;
  logic           dispatch_valid;
  logic           dispatch_ready;
  logic [31:0]    op1, op2, target;
  logic           op1_valid, op2_valid, target_valid;
  logic [4:0]     op1_tag, op2_tag, target_tag;
  rotate_decode_t control_in;
  logic [4:0]     result_reg_addr_in;
  logic           cdb_valid;
  logic [4:0]     cdb_rs_id;
  logic [31:0]    cdb_result;
  logic           issue_valid;
  logic           issue_ready;
  logic [4:0]     issue_rs_id;
  logic [4:0]     issue_result_reg_addr;
  logic [31:0]    issue_op1, issue_op2, issue_target;
  rotate_decode_t issue_control;

  int n_checks = 0;
  int n_errors = 0;

  rot_rs #(.DEPTH(4), .RS_ID_WIDTH(5), .RS_ID_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .op1(op1), .op2(op2), .target(target),
    .op1_valid(op1_valid), .op2_valid(op2_valid), .target_valid(target_valid),
    .op1_tag(op1_tag), .op2_tag(op2_tag), .target_tag(target_tag),
    .control_in(control_in), .result_reg_addr_in(result_reg_addr_in),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs_id(issue_rs_id), .issue_result_reg_addr(issue_result_reg_addr),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_target(issue_target),
    .issue_control(issue_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] t,
                          input logic va, input logic vb, input logic vt,
                          input logic [4:0] ga, input logic [4:0] gb, input logic [4:0] gt);
    dispatch_valid = 1'b1;
    op1 = a;  op2 = b;  target = t;
    op1_valid = va;  op2_valid = vb;  target_valid = vt;
    op1_tag = ga;  op2_tag = gb;  target_tag = gt;
  endtask

  task automatic idle_disp;
    dispatch_valid = 1'b0;
    op1 = '0;  op2 = '0;  target = '0;
    op1_valid = 1'b0;  op2_valid = 1'b0;  target_valid = 1'b0;
    op1_tag = '0;  op2_tag = '0;  target_tag = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle_disp();
    control_in = rotate_decode_t'(10'h2A5);
    result_reg_addr_in = 5'd3;
    cdb_valid = 1'b0;  cdb_rs_id = '0;  cdb_result = '0;
    issue_ready = 1'b0;

    // Reset behaviour, with a dispatch attempt held during reset
    tick();
    set_disp(32'h5555_5555, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    chk("rst_dispatch_ready", dispatch_ready, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_op1", issue_op1, 0);
    tick();
    idle_disp();
    rst = 1'b1;
    #1;
    chk("post_rst_dispatch_ready", dispatch_ready, 1);
    chk("post_rst_issue_valid", issue_valid, 0);

    // Fully valid dispatch with issue_ready=1
    issue_ready = 1'b1;
    set_disp(32'h1234_5678, 32'd4, 32'd0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    #1;
`ifdef ROT_RS_BYPASS_EN
    chk("bypass_same_cycle_valid", issue_valid, 1);
    chk("bypass_rs_id", issue_rs_id, BASE);
    chk("bypass_op1", issue_op1, 32'h1234_5678);
    tick();
    idle_disp();
    #1;
    chk("bypass_no_alloc", issue_valid, 0);
    chk("bypass_ready", dispatch_ready, 1);
`else
    chk("no_bypass_same_cycle", issue_valid, 0);
    tick();
    idle_disp();
    #1;
    chk("t1_issue_valid", issue_valid, 1);
    chk("t1_rs_id", issue_rs_id, BASE);
    chk("t1_op1", issue_op1, 32'h1234_5678);
    chk("t1_op2", issue_op2, 32'd4);
    chk("t1_target", issue_target, 32'd0);
    chk("t1_rd", issue_result_reg_addr, 32'd3);
    chk("t1_ctrl", 32'(issue_control), 32'h2A5);
    tick();
    chk("t1_freed_valid", issue_valid, 0);
    chk("t1_freed_ready", dispatch_ready, 1);
`endif

    // op1 pending on tag 7; op2 is valid but carries tag 7 and must not be overwritten
    set_disp(32'h0, 32'h8, 32'h1F, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd0);
    #1;
    chk("t2_dispatch_cycle_valid", issue_valid, 0);
    tick();
    idle_disp();
    cdb_valid = 1'b1;  cdb_rs_id = 5'd5;  cdb_result = 32'h1111_1111;
    #1;
    chk("t2_wait_valid", issue_valid, 0);
    tick();
    cdb_rs_id = 5'd7;  cdb_result = 32'hDEAD_BEEF;
    #1;
    chk("t2_cdb_cycle_valid", issue_valid, 0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("t2_issue_valid", issue_valid, 1);
    chk("t2_rs_id", issue_rs_id, BASE);
    chk("t2_op1", issue_op1, 32'hDEAD_BEEF);
    chk("t2_op2_kept", issue_op2, 32'h8);
    chk("t2_target", issue_target, 32'h1F);
    tick();
    chk("t2_after_issue", issue_valid, 0);

    // Fill all four entries with issue stalled
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_disp(32'hA0 + 32'(k), 32'd1, 32'd2, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
      #1;
      chk("t3_fill_ready", dispatch_ready, 1);
      tick();
    end
    chk("t3_full_ready", dispatch_ready, 0);
    chk("t3_full_issue_valid", issue_valid, 1);
    chk("t3_full_rs_id", issue_rs_id, BASE);
    chk("t3_full_op1", issue_op1, 32'hA0);
    // One handshake; a dispatch offered while full is not accepted
    issue_ready = 1'b1;
    set_disp(32'hCC, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    issue_ready = 1'b0;
    idle_disp();
    #1;
    chk("t3_freed_ready", dispatch_ready, 1);
    chk("t3_next_rs_id", issue_rs_id, BASE + 1);
    chk("t3_next_op1", issue_op1, 32'hA1);
    set_disp(32'hB0, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    idle_disp();
    #1;
    chk("t3_refull_ready", dispatch_ready, 0);
    chk("t3_reuse_rs_id", issue_rs_id, BASE);
    chk("t3_reuse_op1", issue_op1, 32'hB0);
    issue_ready = 1'b1;
    tick();
    chk("t3_drain1_rs_id", issue_rs_id, BASE + 1);
    chk("t3_drain1_op1", issue_op1, 32'hA1);
    tick();
    chk("t3_drain2_rs_id", issue_rs_id, BASE + 2);
    chk("t3_drain2_op1", issue_op1, 32'hA2);
    tick();
    chk("t3_drain3_rs_id", issue_rs_id, BASE + 3);
    chk("t3_drain3_op1", issue_op1, 32'hA3);
    tick();
    chk("t3_empty_valid", issue_valid, 0);

    // op2 tag matches the broadcast in the dispatch cycle
    issue_ready = 1'b0;
    set_disp(32'h11, 32'h0, 32'h22, 1'b1, 1'b0, 1'b1, 5'd0, 5'd3, 5'd0);
    cdb_valid = 1'b1;  cdb_rs_id = 5'd3;  cdb_result = 32'h1F;
    tick();
    idle_disp();
    cdb_valid = 1'b0;
    #1;
    chk("t4_issue_valid", issue_valid, 1);
    chk("t4_rs_id", issue_rs_id, BASE);
    chk("t4_op2", issue_op2, 32'h1F);
    issue_ready = 1'b1;
    tick();
    chk("t4_after_issue", issue_valid, 0);

    // Two entries wait on tag 9; one broadcast wakes both
    issue_ready = 1'b0;
    set_disp(32'h0, 32'h5, 32'h6, 1'b0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
    tick();
    set_disp(32'h7, 32'h8, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd9);
    tick();
    idle_disp();
    #1;
    chk("t5_waiting_valid", issue_valid, 0);
    set_disp(32'hC1, 32'h1, 32'h1, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    cdb_valid = 1'b1;  cdb_rs_id = 5'd9;  cdb_result = 32'h99;
    tick();
    #1;
    chk("t5_wake_rs_id", issue_rs_id, BASE);
    chk("t5_wake_op1", issue_op1, 32'h99);
    // Dispatch, issue and wake in the same cycle
    issue_ready = 1'b1;
    set_disp(32'h0, 32'h2, 32'h3, 1'b0, 1'b1, 1'b1, 5'd12, 5'd0, 5'd0);
    cdb_rs_id = 5'd12;  cdb_result = 32'h1212;
    tick();
    idle_disp();
    cdb_valid = 1'b0;
    #1;
    chk("t5_second_rs_id", issue_rs_id, BASE + 1);
    chk("t5_second_target", issue_target, 32'h99);
    tick();
    chk("t5_third_rs_id", issue_rs_id, BASE + 2);
    chk("t5_third_op1", issue_op1, 32'hC1);
    tick();
    chk("t5_fourth_rs_id", issue_rs_id, BASE + 3);
    chk("t5_fourth_op1", issue_op1, 32'h1212);
    tick();
    chk("t5_empty_valid", issue_valid, 0);
    chk("t5_empty_ready", dispatch_ready, 1);

    // Reset with a held instruction discards it
    issue_ready = 1'b0;
    set_disp(32'h77, 32'h1, 32'h1, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    idle_disp();
    #1;
    chk("t6_held_valid", issue_valid, 1);
    rst = 1'b0;
    tick();
    chk("t6_in_rst_valid", issue_valid, 0);
    chk("t6_in_rst_ready", dispatch_ready, 0);
    rst = 1'b1;
    issue_ready = 1'b1;
    #1;
    chk("t6_release_ready", dispatch_ready, 1);
    tick();
    chk("t6_discarded_valid", issue_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
